// File: rtl/lrf_window_sched.sv
// Frame scheduler for the KxK sliding-window line-buffer datapath.
// Optional stall-cycle counter: define LRF_SCHED_STALL_CNT_EN.
module lrf_window_sched #(
  parameter int IM_LEN            = 520,
  parameter int IM_HGT            = 520,
  parameter int KER_SIZE          = 3,
  parameter int NO_PARALLEL_UNITS = 4,
  parameter int CNT_W             = 11
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                out_ready,
  output logic                out_valid,
  output logic                clrbuffer,
  output logic                stall,
  output logic [KER_SIZE-2:0] rowend_mask,
  output logic [CNT_W-1:0]    col_idx,
  output logic [CNT_W-1:0]    row_idx,
  output logic                busy,
  output logic                frame_done
`ifdef LRF_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int BPR = IM_LEN / NO_PARALLEL_UNITS;

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(BPR - 1);
  localparam logic [CNT_W-1:0] ROW_PRIME = CNT_W'(KER_SIZE - 2);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IM_HGT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PRIME,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] col_q;
  logic [CNT_W-1:0] row_q;

  logic accept;
  logic col_last;
  logic streaming;

  // Handshake and status decode from the current state.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      PRIME: in_ready = 1'b1;
      RUN: begin
        in_ready  = out_ready;
        out_valid = in_valid & out_ready;
      end
      default: ;
    endcase
    accept     = in_valid & in_ready;
    col_last   = (col_q == COL_LAST);
    streaming  = (state_q == PRIME) | (state_q == RUN);
    stall      = ~(streaming & accept);
    clrbuffer  = (state_q == CLEAR);
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    col_idx    = col_q;
    row_idx    = row_q;
  end

  // Tap i is masked when the current beat is i beats before row end.
  always_comb begin
    rowend_mask = '1;
    for (int i = 0; i < KER_SIZE - 1; i++) begin
      if (state_q != IDLE && col_q == CNT_W'(BPR - 1 - i))
        rowend_mask[i] = 1'b0;
    end
  end

  // Frame sequencing; counters move only on an accepted beat.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_q <= CLEAR;
        end
        CLEAR: begin
          col_q   <= '0;
          row_q   <= '0;
          state_q <= PRIME;
        end
        PRIME: begin
          if (accept) begin
            if (col_last) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
              if (row_q == ROW_PRIME) state_q <= RUN;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (col_last) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                row_q   <= '0;
                state_q <= DONE;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LRF_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of stalled cycles while the frame streams.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stall_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      stall_cnt_q <= '0;
    end else if (streaming && stall && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lrf_window_sched.sv
// Self-checking bench for lrf_window_sched (16x4 image, 4 px/beat, 3x3).
// Per-beat expectations flow through a scoreboard queue.
module tb_lrf_window_sched;

  localparam int CW = 11;

  logic          clk;
  logic          res;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic          clrbuffer;
  logic          stall;
  logic [1:0]    rowend_mask;
  logic [CW-1:0] col_idx;
  logic [CW-1:0] row_idx;
  logic          busy;
  logic          frame_done;
`ifdef LRF_SCHED_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  lrf_window_sched #(
    .IM_LEN(16),
    .IM_HGT(4),
    .KER_SIZE(3),
    .NO_PARALLEL_UNITS(4),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .res(res),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .clrbuffer(clrbuffer),
    .stall(stall),
    .rowend_mask(rowend_mask),
    .col_idx(col_idx),
    .row_idx(row_idx),
    .busy(busy),
    .frame_done(frame_done)
`ifdef LRF_SCHED_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          ov;
    logic [1:0]    mask;
  } beat_t;

  typedef struct {
    logic st;
    logic iv;
    logic ordy;
    logic e_clr;
    logic e_ir;
    logic e_busy;
  } ctl_t;

  beat_t beats[16];
  ctl_t  ctl[5];
  beat_t sb[$];

  int tests;
  int fails;
  int nacc;
  int nfd;
  logic s_acc, s_fd, s_clr, s_busy, s_ir;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic load_sb();
    sb.delete();
    for (int k = 0; k < 16; k++) sb.push_back(beats[k]);
  endtask

  // Drive one cycle of inputs, sample mid-cycle, then advance.
  task automatic step(input logic st, input logic iv, input logic ordy);
    beat_t e;
    start     = st;
    in_valid  = iv;
    out_ready = ordy;
    #3;
    s_acc  = in_valid & in_ready;
    s_fd   = frame_done;
    s_clr  = clrbuffer;
    s_busy = busy;
    s_ir   = in_ready;
    if (s_fd) nfd++;
    chk("stall", {31'd0, stall}, {31'd0, ~s_acc});
    if (s_acc) begin
      nacc++;
      if (sb.size() == 0) begin
        chk("sb_extra_beat", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("beat_col", 32'(col_idx), 32'(e.col));
        chk("beat_row", 32'(row_idx), 32'(e.row));
        chk("beat_ov", {31'd0, out_valid}, {31'd0, e.ov});
        chk("beat_mask", 32'(rowend_mask), 32'(e.mask));
      end
    end else begin
      chk("ov_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  int cyc;
  int hold;
  int since;
  int k;

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 16; i++) begin
      beats[i].col  = CW'(i % 4);
      beats[i].row  = CW'(i / 4);
      beats[i].ov   = (i >= 8);
      beats[i].mask = (i % 4 == 3) ? 2'b10 :
                      (i % 4 == 2) ? 2'b01 : 2'b11;
    end
    ctl[0] = '{st: 0, iv: 0, ordy: 0, e_clr: 0, e_ir: 0, e_busy: 0};
    ctl[1] = '{st: 1, iv: 1, ordy: 1, e_clr: 0, e_ir: 0, e_busy: 0};
    ctl[2] = '{st: 0, iv: 1, ordy: 1, e_clr: 1, e_ir: 0, e_busy: 1};
    ctl[3] = '{st: 0, iv: 0, ordy: 0, e_clr: 0, e_ir: 1, e_busy: 1};
    ctl[4] = '{st: 1, iv: 0, ordy: 0, e_clr: 0, e_ir: 1, e_busy: 1};

    res = 1'b0;
    start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_col", 32'(col_idx), 0);
    chk("rst_row", 32'(row_idx), 0);
    chk("rst_clr", {31'd0, clrbuffer}, 0);
    chk("rst_ir", {31'd0, in_ready}, 0);
    chk("rst_ov", {31'd0, out_valid}, 0);
    chk("rst_fd", {31'd0, frame_done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_stall", {31'd0, stall}, 1);
    chk("rst_mask", 32'(rowend_mask), 32'h3);
    res = 1'b1;
    @(posedge clk);
    #1;

    // Start/clear control sequence, then finish that frame.
    load_sb();
    nacc = 0;
    nfd = 0;
    for (int i = 0; i < 5; i++) begin
      step(ctl[i].st, ctl[i].iv, ctl[i].ordy);
      chk($sformatf("ctl%0d_clr", i), {31'd0, s_clr}, {31'd0, ctl[i].e_clr});
      chk($sformatf("ctl%0d_ir", i), {31'd0, s_ir}, {31'd0, ctl[i].e_ir});
      chk($sformatf("ctl%0d_busy", i), {31'd0, s_busy},
          {31'd0, ctl[i].e_busy});
    end
    cyc = 0;
    while (nfd == 0 && cyc < 60) begin
      step(0, 1, 1);
      cyc++;
    end
    chk("f0_done", 32'(nfd), 1);
    chk("f0_acc", 32'(nacc), 16);
    chk("f0_sb_empty", 32'(sb.size()), 0);

    // Full frame with continuous flow: 18 cycles start to frame_done.
    load_sb();
    nacc = 0;
    nfd = 0;
    step(1, 1, 1);
    cyc = 0;
    while (nfd == 0 && cyc < 60) begin
      step(0, 1, 1);
      cyc++;
    end
    chk("f1_cycles", 32'(cyc), 18);
    chk("f1_acc", 32'(nacc), 16);
    chk("f1_sb_empty", 32'(sb.size()), 0);
    step(0, 0, 0);
    chk("f1_idle", {31'd0, s_busy}, 0);
    chk("f1_fd_once", 32'(nfd), 1);

    // Backpressure: out_ready low in PRIME, and 5 cycles at col 1 row 2.
    load_sb();
    nacc = 0;
    nfd = 0;
    hold = 0;
    step(1, 1, 1);
    cyc = 0;
    while (nfd == 0 && cyc < 80) begin
      if (busy && !clrbuffer && row_idx < 2) begin
        step(0, 1, 0);
      end else if (col_idx == 1 && row_idx == 2 && hold < 5) begin
        step(0, 1, 0);
        hold++;
        chk("bp_ir", {31'd0, s_ir}, 0);
      end else begin
        step(0, 1, 1);
      end
      cyc++;
    end
    chk("bp_hold", 32'(hold), 5);
    chk("bp_cycles", 32'(cyc), 23);
    chk("bp_acc", 32'(nacc), 16);
    chk("bp_sb_empty", 32'(sb.size()), 0);
`ifdef LRF_SCHED_STALL_CNT_EN
    chk("bp_stall_cycles", stall_cycles, 5);
`endif

    // Upstream gaps: in_valid alternates 1,0 from the first PRIME cycle.
    load_sb();
    nacc = 0;
    nfd = 0;
    step(1, 0, 1);
    step(0, 1, 1);
    cyc = 0;
    since = 0;
    while (nfd == 0 && cyc < 80) begin
      step(0, (cyc % 2) == 0, 1);
      if (s_acc) since = 0;
      else since++;
      cyc++;
    end
    chk("gap_acc", 32'(nacc), 16);
    chk("gap_cycles", 32'(cyc), 32);
    chk("gap_fd_after_last", 32'(since), 1);
    chk("gap_sb_empty", 32'(sb.size()), 0);
`ifdef LRF_SCHED_STALL_CNT_EN
    chk("gap_stall_cycles", stall_cycles, 15);
`endif

    // Misuse: start in RUN ignored, then reset mid-RUN.
    load_sb();
    nacc = 0;
    nfd = 0;
    step(1, 1, 1);
    cyc = 0;
    while (!(row_idx == 2 && col_idx == 0) && cyc < 40) begin
      step(0, 1, 1);
      cyc++;
    end
    chk("mis_reach_run", 32'(row_idx), 2);
    step(1, 1, 1);
    step(0, 1, 1);
    chk("mis_no_clr", {31'd0, s_clr}, 0);
    chk("mis_busy", {31'd0, s_busy}, 1);
    chk("mis_col", 32'(col_idx), 2);
    #2;
    res = 1'b0;
    #1;
    chk("mr_col", 32'(col_idx), 0);
    chk("mr_row", 32'(row_idx), 0);
    chk("mr_stall", {31'd0, stall}, 1);
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_ir", {31'd0, in_ready}, 0);
    chk("mr_mask", 32'(rowend_mask), 32'h3);
    k = 0;
    repeat (2) begin
      @(negedge clk);
      if (frame_done) k++;
    end
    chk("mr_no_fd", 32'(k + nfd), 0);
    @(posedge clk);
    #1;
    res = 1'b1;
    step(0, 1, 1);
    chk("mr_stay_idle", {31'd0, s_busy}, 0);

    // Fresh frame after reset.
    load_sb();
    nacc = 0;
    nfd = 0;
    step(1, 1, 1);
    cyc = 0;
    while (nfd == 0 && cyc < 60) begin
      step(0, 1, 1);
      cyc++;
    end
    chk("f2_cycles", 32'(cyc), 18);
    chk("f2_acc", 32'(nacc), 16);
    chk("f2_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lrf_window_sched.md
Name: lrf_window_sched

Overview:
- Frame-level scheduler for the KER_SIZE x KER_SIZE sliding-window line-buffer datapath.
- Each beat carries NO_PARALLEL_UNITS pixels.
- Sequences one frame at a time:
  - clears the line buffers;
  - primes the first KER_SIZE-1 rows;
  - streams windows downstream with a valid/ready handshake;
  - drives the buffer stall and row-end masks, and flags frame completion.
- Sits between the pixel source and the line buffers / parallel filter units.

Parameters:
- IM_LEN, 520, image width in pixels; must be divisible by NO_PARALLEL_UNITS.
- IM_HGT, 520, image height in rows; must be >= KER_SIZE.
- KER_SIZE, 3, window size; line-buffer depth is KER_SIZE-1 rows.
- NO_PARALLEL_UNITS, 4, pixels per beat.
- CNT_W, 11, width of the column and row counters.

Ports:
- clk, input, 1, system clock, rising edge.
- res, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid, input, 1, upstream beat available.
- in_ready, output, 1, scheduler accepts the upstream beat.
- out_ready, input, 1, downstream filter units can take a window.
- out_valid, output, 1, window on the datapath is valid.
- clrbuffer, output, 1, line-buffer clear.
- stall, output, 1, line-buffer shift hold.
- rowend_mask, output, KER_SIZE-1, per-tap row-end mask to the line buffers.
- col_idx, output, CNT_W, current beat index within the row.
- row_idx, output, CNT_W, current row index.
- busy, output, 1, high in every state except IDLE.
- frame_done, output, 1, single-cycle pulse at frame end.

Behaviour:
- Definitions:
  - BPR = IM_LEN/NO_PARALLEL_UNITS.
  - accept = in_valid & in_ready.
- Reset values (res low, immediate; all outputs registered or derived from state):
  - state = IDLE; col_idx = 0; row_idx = 0.
  - clrbuffer = 0, in_ready = 0, out_valid = 0, frame_done = 0, busy = 0.
  - stall = 1; rowend_mask = all ones.
- FSM states: IDLE, CLEAR, PRIME, RUN, DONE.
- IDLE:
  - stall = 1.
  - start -> CLEAR.
- CLEAR:
  - Exactly one cycle with clrbuffer = 1.
  - Counters zeroed.
  - -> PRIME.
- PRIME:
  - in_ready = 1; out_ready is ignored; out_valid = 0.
  - On accept, col_idx increments.
  - When col_idx = BPR-1, col_idx wraps to 0 and row_idx increments.
  - After the accept with col_idx = BPR-1 and row_idx = KER_SIZE-2 -> RUN.
- RUN:
  - in_ready = out_ready.
  - out_valid = in_valid & out_ready, combinational, same cycle as accept (zero latency).
  - Counters step on accept as in PRIME.
  - Accept with col_idx = BPR-1 and row_idx = IM_HGT-1 -> DONE.
- DONE:
  - frame_done = 1 for one cycle; stall = 1.
  - -> IDLE.
- stall = ~accept in PRIME and RUN; stall = 1 in all other states.
- rowend_mask[i] = 0 iff col_idx = BPR-1-i, else 1. Evaluated in all states; all ones when state is IDLE.
- A beat is never dropped or duplicated: counters change only on accept.
- Counter arithmetic is unsigned at CNT_W bits. CNT_W must cover max(BPR, IM_HGT)-1; counters never exceed those limits.
- start while busy is ignored, with no side effects.
- in_valid is ignored in IDLE, CLEAR and DONE (in_ready = 0).
- res asserted mid-frame: immediate return to reset values. No frame_done is emitted; the next frame requires a new start.

Optional Feature:
- Macro: LRF_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0].
  - Counts cycles in PRIME or RUN with stall = 1.
  - Cleared to 0 in CLEAR and on reset.
  - Holds its value through DONE/IDLE; saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
All scenarios use IM_LEN=16, NO_PARALLEL_UNITS=4 (BPR=4), IM_HGT=4, KER_SIZE=3.
- Start and clear: start pulse in IDLE -> clrbuffer = 1 for exactly the next cycle, busy = 1, then in_ready = 1 from the following cycle.
- Full frame:
  - Stimulus: in_valid and out_ready held at 1.
  - Beats 1-8: out_valid = 0.
  - Beats 9-16: out_valid = 1.
  - frame_done pulses one cycle after beat 16; 18 cycles from start to frame_done; back to IDLE.
- Row-end mask: rowend_mask = 2'b10 at col_idx 3, 2'b01 at col_idx 2, 2'b11 at col_idx 0/1 on every row.
- Backpressure:
  - out_ready = 0 for 5 cycles in RUN at col_idx 1, row_idx 2 -> in_ready = 0, stall = 1, counters held at 1/2; frame still completes with 16 accepts.
  - out_ready = 0 during PRIME -> no effect.
  - With LRF_SCHED_STALL_CNT_EN: stall_cycles = 5.
- Upstream gaps: in_valid toggled 1,0 every cycle -> 16 accepts over 32 cycles, stall = 1 on every in_valid = 0 cycle, frame_done after the 16th accept.
- Misuse and reset:
  - start pulsed in RUN -> ignored, with no clrbuffer.
  - res low mid-RUN (row_idx 2) -> immediately state IDLE, counters 0, stall = 1, no frame_done.
  - After reset release, a new start runs a full frame correctly.
